led_scanner: RTL and testbench
==============================

// Module: led_scanner
// PURPOSE
//   Pattern generator driving the eight board LEDs (LED0..LED7) of the icezum.
//   Produces bounce / rotate / binary-count patterns advanced by a prescaled tick,
//   with global PWM brightness. Sits upstream of the LED pins, replacing static drive.
// PARAMETERS
//   DIV   1200000  clk cycles per pattern step (10 Hz at 12 MHz); DIV>=1; counter width $clog2(DIV) (min 1)
// PORTS
//   clk     in   1  system clock
//   rst     in   1  asynchronous reset, active-high
//   mode    in   2  0=OFF 1=BOUNCE 2=ROTATE 3=COUNT
//   bright  in   3  brightness: 0=dark, 1..6=bright/8 duty, 7=always on
//   pause   in   1  1=freeze prescaler and pattern
//   step    out  1  one-cycle pulse per pattern advance
//   LED0..LED7  out  1 each  LED drive, LEDn = pattern bit n, gated
// BEHAVIOUR
// - Reset (async): pat=8'h01, dir=0 (toward LED7), prescaler=0, pwm_cnt=0, mode_q=0,
//   LED0..7=0, step=0. All outputs registered.
// - Prescaler: counts 0..DIV-1 while pause=0; tick when count==DIV-1 and pause=0, count->0.
//   pause=1 holds count; no tick. DIV=1: tick every unpaused cycle.
// - mode_q registers mode every clk. If mode!=mode_q (mode change), next edge: prescaler->0,
//   no tick, no step; pat reload: BOUNCE/ROTATE->8'h01,dir=0; COUNT->8'h00; OFF->hold.
//   Mode change has priority over a coincident tick.
// - On tick (edge): step<=1 for that cycle only, pat updates the same edge:
//   OFF: pat held. BOUNCE: dir=0: pat<<1, but pat==80 -> pat=40,dir=1;
//   dir=1: pat>>1, but pat==01 -> pat=02,dir=0 (14-step period, no dwell at ends).
//   ROTATE: pat={pat[6:0],pat[7]}. COUNT: pat=pat+1 mod 256 (FF->00).
//   step also pulses in OFF mode.
// - PWM: pwm_cnt 3-bit free-running, +1 every clk, wraps 7->0.
//   gate = (bright==7) | (pwm_cnt < bright).
// - LEDn <= pat[n] & gate & (mode!=0): one clk after pat/pwm_cnt change.
//   mode==0 -> all LEDs 0 next clk.
// - Asynchronous rst mid-operation: LEDs and step go 0 immediately;
//   sequence restarts at 8'h01 on release, first step DIV cycles after release.
// - Inputs mode/bright/pause sampled synchronously; no internal synchronisers.
// TESTING (DIV=4, clk period 1 unit)
// - Reset/bounce start: rst=1 -> LEDs=00,step=0; release with mode=1,bright=7,
//   pause=0 -> LED0=1 after 2 clks; step every 4 clks; LEDs 01,02,04..80,40..02,01,02.
// - Bounce ends: 14 steps from 01 returns to 01; 80 and 01 each appear once per period;
//   dir flips exactly at ends.
// - Rotate/count: mode 1->2 mid-sequence -> LEDs=01 within 2 clks; 8 steps later 01
//   again (80->01). Mode 2->3 -> LEDs=00 then 01,02,03; preload via 255 steps -> FF->00 wrap.
// - PWM: mode=2, pause=1, bright=3 -> LED0 high exactly 3 of every 8 clks, others 0;
//   bright=0 -> never high; bright=7 -> constant high.
// - Pause: pause=1 for 20 clks -> no step, LEDs pattern unchanged;
//   pause=0 -> prescaler resumes from held count (next step <=4 clks).
// - Mid reset/mode race: rst pulse mid-cycle at pat=20 -> LEDs 0 before next edge,
//   01 after release. Mode change on tick cycle -> reload wins, no step that cycle.

Source files
------------

// File: rtl/led_scanner.sv
// ---------------------------------------------------------------------------
// led_scanner
//   Pattern generator for the eight board LEDs. A prescaler divides clk down
//   to one pattern step every DIV cycles; the pattern is a bouncing dot, a
//   rotating dot or an 8-bit binary count. A 3-bit free-running PWM counter
//   sets a global brightness. Every output is registered.
//
// Parameters
//   DIV        clk cycles per pattern step (DIV >= 1)
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active high
//   mode       in   [1:0] 0=OFF 1=BOUNCE 2=ROTATE 3=COUNT
//   bright     in   [2:0] 0=dark, 1..6=bright/8 duty, 7=always on
//   pause      in   1 freezes prescaler and pattern
//   step       out  one-cycle pulse per pattern advance
//   LED0..LED7 out  LEDn = pattern bit n, gated by PWM and mode
// ---------------------------------------------------------------------------
module led_scanner #(
  parameter int unsigned DIV = 32'd1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [2:0] bright,
  input  logic       pause,
  output logic       step,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic       LED6,
  output logic       LED7
);

  // A one-state counter still needs one bit of storage.
  localparam int unsigned CW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 32'd1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  // Bounce: returns {dir, pat}. The end positions reverse in the same step,
  // so neither end dwells and a full period is 14 steps.
  function automatic logic [8:0] bounce_next(input logic [7:0] pat, input logic dir);
    logic [8:0] res;
    res = {dir, pat};
    if (dir == 1'b0) begin
      if (pat == 8'h80) begin
        res = {1'b1, 8'h40};
      end else begin
        res = {1'b0, pat[6:0], 1'b0};
      end
    end else begin
      if (pat == 8'h01) begin
        res = {1'b0, 8'h02};
      end else begin
        res = {1'b1, 1'b0, pat[7:1]};
      end
    end
    return res;
  endfunction

  // Rotate toward LED7 with wrap from LED7 back to LED0.
  function automatic logic [7:0] rotate_next(input logic [7:0] pat);
    return {pat[6:0], pat[7]};
  endfunction

  // PWM gate: level 7 is fully on, otherwise on for 'level' of 8 phases.
  function automatic logic pwm_gate(input logic [2:0] level, input logic [2:0] phase);
    return (level == 3'd7) || (phase < level);
  endfunction

  logic [CW-1:0] presc_q, presc_d;
  logic [7:0]    pat_q,   pat_d;
  logic          dir_q,   dir_d;
  logic [2:0]    pwm_q,   pwm_d;
  mode_e         mode_q,  mode_d;
  logic [7:0]    led_q,   led_d;
  logic          step_q,  step_d;

  logic          mode_chg_s;
  logic          tick_s;
  logic [8:0]    bounce_s;

  // Next-state logic: prescaler, pattern, PWM phase and output drive.
  always_comb begin
    mode_d     = mode_e'(mode);
    mode_chg_s = (mode != mode_q);
    // A mode change suppresses a coincident tick so the reload wins.
    tick_s     = !mode_chg_s && !pause && (presc_q == PRESC_LAST);
    bounce_s   = bounce_next(pat_q, dir_q);

    presc_d = presc_q;
    if (mode_chg_s) begin
      presc_d = '0;
    end else if (pause) begin
      presc_d = presc_q;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + CW'(1);
    end

    pat_d = pat_q;
    dir_d = dir_q;
    if (mode_chg_s) begin
      case (mode)
        MODE_BOUNCE, MODE_ROTATE: begin
          pat_d = 8'h01;
          dir_d = 1'b0;
        end
        MODE_COUNT: begin
          pat_d = 8'h00;
        end
        default: begin
          pat_d = pat_q;
        end
      endcase
    end else if (tick_s) begin
      case (mode_q)
        MODE_BOUNCE: begin
          pat_d = bounce_s[7:0];
          dir_d = bounce_s[8];
        end
        MODE_ROTATE: begin
          pat_d = rotate_next(pat_q);
        end
        MODE_COUNT: begin
          pat_d = pat_q + 8'd1;
        end
        default: begin
          pat_d = pat_q;
        end
      endcase
    end else begin
      pat_d = pat_q;
    end

    pwm_d  = pwm_q + 3'd1;
    step_d = tick_s;

    // LEDs show the current pattern register, so they trail a pattern
    // update by one clock.
    if ((mode != 2'd0) && pwm_gate(bright, pwm_q)) begin
      led_d = pat_q;
    end else begin
      led_d = 8'h00;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pat_q   <= 8'h01;
      dir_q   <= 1'b0;
      pwm_q   <= 3'd0;
      mode_q  <= MODE_OFF;
      led_q   <= 8'h00;
      step_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      pwm_q   <= pwm_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign step = step_q;
  assign LED0 = led_q[0];
  assign LED1 = led_q[1];
  assign LED2 = led_q[2];
  assign LED3 = led_q[3];
  assign LED4 = led_q[4];
  assign LED5 = led_q[5];
  assign LED6 = led_q[6];
  assign LED7 = led_q[7];

endmodule

// File: tb/tb_led_scanner.sv
`timescale 1ns/1ps
// Testbench for led_scanner with DIV=4. Expected LED patterns are queued
// when a scenario starts and popped as each step pulse is observed.
module tb_led_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [2:0] bright = 3'd0;
  logic       pause = 1'b0;
  logic       step;
  logic [7:0] led;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  led_scanner #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .bright(bright), .pause(pause), .step(step),
    .LED0(led[0]), .LED1(led[1]), .LED2(led[2]), .LED3(led[3]),
    .LED4(led[4]), .LED5(led[5]), .LED6(led[6]), .LED7(led[7])
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advances negedge by negedge until step is seen or the bound expires.
  task automatic wait_step(output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 40) begin
      @(negedge clk);
      waited++;
      if (step === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h expected 00", led); end
    checks++;
    if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
  endtask

  task automatic test_bounce;
    bit seen; int waited; logic [7:0] e;
    @(negedge clk);
    mode = 2'd1; bright = 3'd7; pause = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL bounce_start: got %h expected 01", led); end
    checks++;
    if (step !== 1'b0) begin errors++; $display("FAIL bounce_early_step: got %b expected 0", step); end
    // 15 steps: one full 14-step period plus one more past the LED0 end.
    foreach (e_list_bounce[i]) exp_q.push_back(e_list_bounce[i]);
    while (exp_q.size() > 0) begin
      wait_step(seen, waited);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL bounce_step: no step in %0d cycles, expected one", waited);
        exp_q.delete();
      end else begin
        checks++;
        if (waited !== 3) begin errors++; $display("FAIL bounce_period: got %0d expected 3", waited); end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (led !== e) begin errors++; $display("FAIL bounce_pattern: got %h expected %h", led, e); end
      end
    end
  endtask

  logic [7:0] e_list_bounce [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  task automatic test_rotate;
    bit seen; int waited; logic [7:0] e;
    @(negedge clk);
    mode = 2'd2;
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL rotate_reload: got %h expected 01", led); end
    e = 8'h01;
    for (int i = 0; i < 8; i++) begin
      e = {e[6:0], e[7]};
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0) begin
      wait_step(seen, waited);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rotate_step: no step in %0d cycles, expected one", waited);
        exp_q.delete();
      end else begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (led !== e) begin errors++; $display("FAIL rotate_pattern: got %h expected %h", led, e); end
      end
    end
  endtask

  task automatic test_count;
    bit seen; int waited; logic [7:0] e;
    @(negedge clk);
    mode = 2'd3;
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL count_reload: got %h expected 00", led); end
    for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
    while (exp_q.size() > 0) begin
      wait_step(seen, waited);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL count_step: no step in %0d cycles, expected one", waited);
        exp_q.delete();
      end else begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (led !== e) begin errors++; $display("FAIL count_pattern: got %h expected %h", led, e); end
      end
    end
  endtask

  task automatic test_pwm;
    logic [2:0] lv [4] = '{3'd3, 3'd0, 3'd7, 3'd5};
    int hi, other, steps, want;
    @(negedge clk);
    mode = 2'd2; pause = 1'b1;
    foreach (lv[k]) begin
      bright = lv[k];
      want = (lv[k] == 3'd7) ? 8 : int'(lv[k]);
      repeat (2) @(negedge clk);
      hi = 0; other = 0; steps = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (led[0] === 1'b1) hi++;
        if (led[7:1] !== 7'd0) other++;
        if (step !== 1'b0) steps++;
      end
      checks++;
      if (hi !== want) begin errors++; $display("FAIL pwm_duty: bright=%0d got %0d of 8 expected %0d", lv[k], hi, want); end
      checks++;
      if (other !== 0) begin errors++; $display("FAIL pwm_others: got %0d lit cycles expected 0", other); end
      checks++;
      if (steps !== 0) begin errors++; $display("FAIL pwm_paused_step: got %0d expected 0", steps); end
    end
  endtask

  task automatic test_pause;
    bit seen; int waited; int bad;
    @(negedge clk);
    mode = 2'd1; bright = 3'd7; pause = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL pause_reload: got %h expected 01", led); end
    wait_step(seen, waited);
    @(negedge clk);
    checks++;
    if (!seen || led !== 8'h02) begin errors++; $display("FAIL pause_prestep: got %h expected 02", led); end
    // Prescaler now holds 1, so after release the tick comes 3 edges later.
    pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step !== 1'b0 || led !== 8'h02) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL pause_hold: got %0d disturbed cycles expected 0", bad); end
    pause = 1'b0;
    wait_step(seen, waited);
    checks++;
    if (!seen || waited !== 3) begin errors++; $display("FAIL pause_resume: got %0d cycles (seen=%0b) expected 3", waited, seen); end
    @(negedge clk);
    checks++;
    if (led !== 8'h04) begin errors++; $display("FAIL pause_after: got %h expected 04", led); end
  endtask

  task automatic test_mode_race;
    bit seen; int waited;
    // Prescaler is at 1 here; two more edges bring it to the tick value.
    repeat (2) @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    checks++;
    if (step !== 1'b0) begin errors++; $display("FAIL race_step: got %b expected 0", step); end
    @(negedge clk);
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL race_reload: got %h expected 01", led); end
    wait_step(seen, waited);
    checks++;
    if (!seen || waited !== 3) begin errors++; $display("FAIL race_restart: got %0d cycles (seen=%0b) expected 3", waited, seen); end
    @(negedge clk);
    checks++;
    if (led !== 8'h02) begin errors++; $display("FAIL race_next: got %h expected 02", led); end
  endtask

  task automatic test_off;
    bit seen; int waited;
    @(negedge clk);
    mode = 2'd0;
    @(negedge clk);
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL off_leds: got %h expected 00", led); end
    wait_step(seen, waited);
    checks++;
    if (!seen || waited !== 4) begin errors++; $display("FAIL off_step: got %0d cycles (seen=%0b) expected 4", waited, seen); end
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL off_dark: got %h expected 00", led); end
  endtask

  task automatic test_mid_reset;
    bit seen; int waited; logic [7:0] e;
    @(negedge clk);
    mode = 2'd1;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    while (exp_q.size() > 0) begin
      wait_step(seen, waited);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL midrst_step: no step in %0d cycles, expected one", waited);
        exp_q.delete();
      end else begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (led !== e) begin errors++; $display("FAIL midrst_pattern: got %h expected %h", led, e); end
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (led !== 8'h00 || step !== 1'b0) begin errors++; $display("FAIL midrst_async: got led=%h step=%b expected 00/0", led, step); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL midrst_restart: got %h expected 01", led); end
    wait_step(seen, waited);
    checks++;
    if (!seen || waited !== 3) begin errors++; $display("FAIL midrst_first_step: got %0d cycles (seen=%0b) expected 3", waited, seen); end
    @(negedge clk);
    checks++;
    if (led !== 8'h02) begin errors++; $display("FAIL midrst_next: got %h expected 02", led); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_rotate();
    test_count();
    test_pwm();
    test_pause();
    test_mode_race();
    test_off();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
